ropuf_eval_ctrl: RTL

ROPUF_EVAL_CTRL -- requirements
Module: ropuf_eval_ctrl

---
 rtl/ropuf_pkg.sv | 18 +
 rtl/ropuf_window_timer.sv | 27 ++
 rtl/ropuf_eval_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ropuf_pkg.sv
// Shared types and constants for the RO-PUF evaluation controller.
package ropuf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MEASURE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  localparam int unsigned SETTLE_CYCLES  = 2;
  localparam int unsigned N_BITS_DEF     = 8;
  localparam int unsigned SEL_W_DEF      = 3;
  localparam int unsigned WIN_CYCLES_DEF = 16;

endpackage

// File: rtl/ropuf_window_timer.sv
// Loadable down-counter; expire_o pulses in the last enabled cycle of a window.
module ropuf_window_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expire_o = en_i && (count_q == W'(1));

endmodule

// File: rtl/ropuf_eval_ctrl.sv
// RO-PUF evaluation sequencer: per bit CLEAR -> MEASURE -> SETTLE -> CAPTURE.
// Define ROPUF_MAJORITY_EN to measure each bit three times and take a majority vote.
module ropuf_eval_ctrl
  import ropuf_pkg::*;
#(
  parameter int unsigned N_BITS     = N_BITS_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned WIN_CYCLES = WIN_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  input  logic               comp,
  output logic               ro_en,
  output logic               cnt_clr,
  output logic [SEL_W-1:0]   sel0,
  output logic [SEL_W-1:0]   sel1,
  output logic               busy,
  output logic [N_BITS-1:0]  resp,
  output logic               resp_valid,
  input  logic               resp_ack
);

  localparam int unsigned KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [SEL_W-1:0]   off_q, off_d;
  logic [SEL_W-1:0]   sel0_q, sel0_d, sel1_q, sel1_d;
  logic [N_BITS-1:0]  resp_q, resp_d;
  logic               valid_q, valid_d;
  logic               tmr_load, tmr_en, tmr_expire;
  logic [7:0]         tmr_val;
  logic               last_pass, bit_val;
  logic [SEL_W-1:0]   ch_base, ch_off;

  assign ch_base = challenge[SEL_W-1:0];
  // A zero offset would select the same RO twice, so it is promoted to 1.
  assign ch_off  = (challenge[2*SEL_W-1:SEL_W] == '0) ? SEL_W'(1)
                                                      : challenge[2*SEL_W-1:SEL_W];

`ifdef ROPUF_MAJORITY_EN
  logic [1:0] pass_q, pass_d, votes_q, votes_d;

  assign last_pass = (pass_q == 2'd2);
  assign bit_val   = (votes_q == 2'd2) || ((votes_q == 2'd1) && comp);

  always_comb begin
    pass_d  = pass_q;
    votes_d = votes_q;
    if (state_q == S_CAPTURE) begin
      if (last_pass) begin
        pass_d  = '0;
        votes_d = '0;
      end else begin
        pass_d  = pass_q + 2'd1;
        votes_d = votes_q + {1'b0, comp};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q  <= '0;
      votes_q <= '0;
    end else begin
      pass_q  <= pass_d;
      votes_q <= votes_d;
    end
  end
`else
  assign last_pass = 1'b1;
  assign bit_val   = comp;
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    off_d    = off_q;
    sel0_d   = sel0_q;
    sel1_d   = sel1_q;
    resp_d   = resp_q;
    valid_d  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = 8'(WIN_CYCLES);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d   = ch_off;
          sel0_d  = ch_base;
          sel1_d  = ch_base + ch_off;
          resp_d  = '0;
          k_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tmr_load = 1'b1;
        state_d  = S_MEASURE;
      end
      S_MEASURE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = 8'(SETTLE_CYCLES);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_CLEAR;
        if (last_pass) begin
          resp_d[k_q] = bit_val;
          if (k_q == KW'(N_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            k_d    = k_q + KW'(1);
            sel0_d = sel0_q + SEL_W'(1);
            sel1_d = sel0_q + SEL_W'(1) + off_q;
          end
        end
      end
      S_DONE: begin
        // resp_valid is registered, so it rises one cycle after DONE is entered.
        valid_d = 1'b1;
        if (valid_q && resp_ack) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      off_q   <= '0;
      sel0_q  <= '0;
      sel1_q  <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      off_q   <= off_d;
      sel0_q  <= sel0_d;
      sel1_q  <= sel1_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
    end
  end

  ropuf_window_timer #(.W(8)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  assign ro_en      = (state_q == S_MEASURE);
  assign cnt_clr    = (state_q == S_CLEAR);
  assign busy       = (state_q != S_IDLE);
  assign sel0       = sel0_q;
  assign sel1       = sel1_q;
  assign resp       = resp_q;
  assign resp_valid = valid_q;

endmodule
